// File: rtl/card_sprite_if.sv
// card_sprite_if: image-write request handshake plus the two sprite memory
// ports (read and write) of card_sprite_ctrl.
//   wr_req/wr_addr/wr_data -> controller, wr_ack <- controller
//   WE/wAddr/dataIn        : memory write port driven by the controller
//   RE/rAddr               : memory read port driven by the controller
//   dataOut                : memory read data (one-cycle registered latency)
// slave  = controller view, master = requester/memory view.
interface card_sprite_if #(
    parameter int AW = 9,
    parameter int CW = 3
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          wr_ack;
    logic          WE;
    logic          RE;
    logic [AW-1:0] wAddr;
    logic [AW-1:0] rAddr;
    logic [CW-1:0] dataIn;
    logic [CW-1:0] dataOut;

    modport slave (
        input  wr_req, wr_addr, wr_data, dataOut,
        output wr_ack, WE, RE, wAddr, rAddr, dataIn
    );

    modport master (
        output wr_req, wr_addr, wr_data, dataOut,
        input  wr_ack, WE, RE, wAddr, rAddr, dataIn
    );
endinterface

// File: rtl/card_sprite_ctrl.sv
// card_sprite_ctrl: maps the raster position onto a SPR_W x SPR_H card image
// at a frame-latched screen position, drives the sprite memory read port and
// returns a registered colour/hit pair three cycles after the raster inputs.
// Image updates are granted on the write port only outside active video.
// Ports:
//   clk, rst            pixel clock, async active-high reset
//   hcount, vcount      raster position; active = visible pixel
//   frame_start         one-cycle pulse at frame start (position update point)
//   card_x/card_y       requested top-left, captured by pos_load
//   bus                 write handshake + memory ports (card_sprite_if.slave)
//   pix_hit/pix_color   opaque-pixel flag and colour (TRANSP when no hit)
module card_sprite_ctrl #(
    parameter int            SPR_W  = 16,
    parameter int            SPR_H  = 32,
    parameter int            AW     = 9,
    parameter int            CW     = 3,
    parameter logic [CW-1:0] TRANSP = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    hcount,
    input  logic [7:0]    vcount,
    input  logic          active,
    input  logic          frame_start,
    input  logic [7:0]    card_x,
    input  logic [7:0]    card_y,
    input  logic          pos_load,
    card_sprite_if.slave  bus,
    output logic          pix_hit,
    output logic [CW-1:0] pix_color
);
    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    typedef enum logic {IDLE, WRITE} wr_state_e;

    // Position registers: pending (host-visible) and live (used by raster)
    logic [7:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

    // Read pipeline
    logic [AW-1:0] raddr_q, raddr_d;
    logic          re_q, re_d;
    logic          hit1_q, hit1_d, hit2_q, hit2_d;
    logic          pix_hit_q, pix_hit_d;
    logic [CW-1:0] pix_color_q, pix_color_d;

    // Write arbiter
    wr_state_e     state_q, state_d;
    logic          we_q, we_d, ack_q, ack_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [CW-1:0] wdata_q, wdata_d;

    logic [8:0] dx, dy;
    logic       in_spr;

    // Negative offsets set bit 8, so the card never wraps around the screen.
    assign dx     = {1'b0, hcount} - {1'b0, cur_x_q};
    assign dy     = {1'b0, vcount} - {1'b0, cur_y_q};
    assign in_spr = active && !dx[8] && (dx < 9'(SPR_W))
                           && !dy[8] && (dy < 9'(SPR_H));

    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        if (pos_load) begin
            pend_x_d = card_x;
            pend_y_d = card_y;
        end
        // Live position only moves at frame start; a simultaneous load
        // bypasses the pending stage.
        if (frame_start) begin
            cur_x_d = pos_load ? card_x : pend_x_q;
            cur_y_d = pos_load ? card_y : pend_y_q;
        end
    end

    always_comb begin
        raddr_d     = in_spr ? AW'({dy[YB-1:0], dx[XB-1:0]}) : raddr_q;
        re_d        = in_spr;
        hit1_d      = in_spr;
        hit2_d      = hit1_q;   // aligns with dataOut from the memory
        pix_hit_d   = hit2_q && (bus.dataOut != TRANSP);
        pix_color_d = hit2_q ? bus.dataOut : TRANSP;
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (bus.wr_req && !active) begin
                state_d = WRITE;
                we_d    = 1'b1;
                ack_d   = 1'b1;
                waddr_d = bus.wr_addr;
                wdata_d = bus.wr_data;
            end
            // One dead cycle lets the requester retire the acked request.
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            raddr_q     <= '0;
            re_q        <= 1'b0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            pix_hit_q   <= 1'b0;
            pix_color_q <= TRANSP;
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ack_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            raddr_q     <= raddr_d;
            re_q        <= re_d;
            hit1_q      <= hit1_d;
            hit2_q      <= hit2_d;
            pix_hit_q   <= pix_hit_d;
            pix_color_q <= pix_color_d;
            state_q     <= state_d;
            we_q        <= we_d;
            ack_q       <= ack_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.rAddr  = raddr_q;
    assign bus.RE     = re_q;
    assign bus.WE     = we_q;
    assign bus.wr_ack = ack_q;
    assign bus.wAddr  = waddr_q;
    assign bus.dataIn = wdata_q;
    assign pix_hit    = pix_hit_q;
    assign pix_color  = pix_color_q;
endmodule

// File: tb/tb_card_sprite_ctrl.sv
// Directed bench for card_sprite_ctrl with a 512 x 3 registered-read memory
// model preloaded with address[2:0]. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_card_sprite_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hcount, vcount, card_x, card_y;
    logic       active, frame_start, pos_load, pix_hit;
    logic [2:0] pix_color;
    logic       mem_init;
    logic [2:0] mem [512];
    int tests = 0;
    int fails = 0;

    card_sprite_if #(.AW(9), .CW(3)) bus_if ();

    card_sprite_ctrl dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .active(active), .frame_start(frame_start), .card_x(card_x),
        .card_y(card_y), .pos_load(pos_load), .bus(bus_if),
        .pix_hit(pix_hit), .pix_color(pix_color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 3'(i);
            bus_if.dataOut <= 3'b000;
        end else begin
            if (bus_if.WE) mem[bus_if.wAddr] <= bus_if.dataIn;
            if (bus_if.RE) bus_if.dataOut <= mem[bus_if.rAddr];
        end
    end

    task automatic px(input logic [7:0] h, input logic [7:0] v, input logic a);
        @(negedge clk);
        hcount = h; vcount = v; active = a;
    endtask

    task automatic load_pos(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        card_x = x; card_y = y; pos_load = 1'b1; frame_start = 1'b1; active = 1'b0;
        @(negedge clk);
        pos_load = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL reset_re got=%0h exp=0", bus_if.RE); end
        tests++; if (bus_if.WE !== 1'b0) begin fails++; $display("FAIL reset_we got=%0h exp=0", bus_if.WE); end
        tests++; if (bus_if.wr_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%0h exp=0", bus_if.wr_ack); end
        tests++; if (bus_if.rAddr !== 9'd0) begin fails++; $display("FAIL reset_raddr got=%0h exp=0", bus_if.rAddr); end
        tests++; if (bus_if.wAddr !== 9'd0) begin fails++; $display("FAIL reset_waddr got=%0h exp=0", bus_if.wAddr); end
        tests++; if (pix_hit !== 1'b0 || pix_color !== 3'b000) begin fails++; $display("FAIL reset_pix got=%0h/%0h exp=0/0", pix_hit, pix_color); end
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
    endtask

    task automatic test_hit;
        load_pos(8'd100, 8'd50);
        px(8'd100, 8'd50, 1'b1);
        @(negedge clk);
        tests++; if (bus_if.rAddr !== 9'd0 || bus_if.RE !== 1'b1) begin fails++; $display("FAIL hit_origin_raddr got=%0d/%0h exp=0/1", bus_if.rAddr, bus_if.RE); end
        active = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (pix_hit !== 1'b0 || pix_color !== 3'b000) begin fails++; $display("FAIL hit_origin_pix got=%0h/%0h exp=0/0", pix_hit, pix_color); end
        px(8'd105, 8'd52, 1'b1);
        @(negedge clk);
        tests++; if (bus_if.rAddr !== 9'd37 || bus_if.RE !== 1'b1) begin fails++; $display("FAIL hit_37_raddr got=%0d/%0h exp=37/1", bus_if.rAddr, bus_if.RE); end
        active = 1'b0;
        @(negedge clk);
        tests++; if (pix_hit !== 1'b0) begin fails++; $display("FAIL hit_37_early got=%0h exp=0", pix_hit); end
        @(negedge clk);
        tests++; if (pix_hit !== 1'b1 || pix_color !== 3'b101) begin fails++; $display("FAIL hit_37_pix got=%0h/%0h exp=1/5", pix_hit, pix_color); end
    endtask

    task automatic test_bounds;
        px(8'd115, 8'd81, 1'b1);
        @(negedge clk);
        tests++; if (bus_if.rAddr !== 9'd511 || bus_if.RE !== 1'b1) begin fails++; $display("FAIL bound_corner got=%0d/%0h exp=511/1", bus_if.rAddr, bus_if.RE); end
        hcount = 8'd116; vcount = 8'd50;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0 || bus_if.rAddr !== 9'd511) begin fails++; $display("FAIL bound_right got=%0h/%0d exp=0/511", bus_if.RE, bus_if.rAddr); end
        hcount = 8'd100; vcount = 8'd82;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL bound_bottom got=%0h exp=0", bus_if.RE); end
        hcount = 8'd99; vcount = 8'd50;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL bound_left got=%0h exp=0", bus_if.RE); end
        hcount = 8'd105; vcount = 8'd52; active = 1'b0;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL bound_inactive got=%0h exp=0", bus_if.RE); end
    endtask

    task automatic test_write_arb;
        @(negedge clk);
        hcount = 8'd0; vcount = 8'd0; active = 1'b1;
        bus_if.wr_req = 1'b1; bus_if.wr_addr = 9'h1FF; bus_if.wr_data = 3'b110;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++; if (bus_if.WE !== 1'b0 || bus_if.wr_ack !== 1'b0) begin fails++; $display("FAIL wr_blocked c=%0d got=%0h/%0h exp=0/0", c, bus_if.WE, bus_if.wr_ack); end
        end
        active = 1'b0;
        @(negedge clk);
        tests++; if (bus_if.WE !== 1'b1 || bus_if.wr_ack !== 1'b1) begin fails++; $display("FAIL wr_grant got=%0h/%0h exp=1/1", bus_if.WE, bus_if.wr_ack); end
        tests++; if (bus_if.wAddr !== 9'h1FF || bus_if.dataIn !== 3'b110) begin fails++; $display("FAIL wr_grant_data got=%0h/%0h exp=1ff/6", bus_if.wAddr, bus_if.dataIn); end
        bus_if.wr_req = 1'b0;
        @(negedge clk);
        tests++; if (bus_if.WE !== 1'b0 || bus_if.wr_ack !== 1'b0) begin fails++; $display("FAIL wr_pulse_end got=%0h/%0h exp=0/0", bus_if.WE, bus_if.wr_ack); end
        px(8'd115, 8'd81, 1'b1);
        @(negedge clk);
        active = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (pix_hit !== 1'b1 || pix_color !== 3'b110) begin fails++; $display("FAIL wr_readback got=%0h/%0h exp=1/6", pix_hit, pix_color); end
    endtask

    task automatic test_clip;
        load_pos(8'd250, 8'd230);
        px(8'd255, 8'd239, 1'b1);
        @(negedge clk);
        tests++; if (bus_if.rAddr !== 9'd149 || bus_if.RE !== 1'b1) begin fails++; $display("FAIL clip_edge got=%0d/%0h exp=149/1", bus_if.rAddr, bus_if.RE); end
        hcount = 8'd0; vcount = 8'd0;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL clip_wrap_re got=%0h exp=0", bus_if.RE); end
        tests++; if (pix_hit !== 1'b0) begin fails++; $display("FAIL clip_early got=%0h exp=0", pix_hit); end
        @(negedge clk);
        tests++; if (pix_hit !== 1'b1 || pix_color !== 3'b101) begin fails++; $display("FAIL clip_edge_pix got=%0h/%0h exp=1/5", pix_hit, pix_color); end
        @(negedge clk);
        tests++; if (pix_hit !== 1'b0 || pix_color !== 3'b000) begin fails++; $display("FAIL clip_wrap_pix got=%0h/%0h exp=0/0", pix_hit, pix_color); end
        active = 1'b0;
    endtask

    task automatic test_pos_latch;
        @(negedge clk);
        card_x = 8'd20; card_y = 8'd20; pos_load = 1'b1;
        @(negedge clk);
        pos_load = 1'b0; hcount = 8'd20; vcount = 8'd20; active = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL pos_pending_new got=%0h exp=0", bus_if.RE); end
        hcount = 8'd255; vcount = 8'd239;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b1 || bus_if.rAddr !== 9'd149) begin fails++; $display("FAIL pos_pending_old got=%0h/%0d exp=1/149", bus_if.RE, bus_if.rAddr); end
        active = 1'b0; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; hcount = 8'd20; vcount = 8'd20; active = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b1 || bus_if.rAddr !== 9'd0) begin fails++; $display("FAIL pos_frame_apply got=%0h/%0d exp=1/0", bus_if.RE, bus_if.rAddr); end
        active = 1'b0; card_x = 8'd40; card_y = 8'd40; pos_load = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        pos_load = 1'b0; frame_start = 1'b0; hcount = 8'd40; vcount = 8'd41; active = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b1 || bus_if.rAddr !== 9'd16) begin fails++; $display("FAIL pos_same_cycle got=%0h/%0d exp=1/16", bus_if.RE, bus_if.rAddr); end
        hcount = 8'd20; vcount = 8'd20;
        @(negedge clk);
        tests++; if (bus_if.RE !== 1'b0) begin fails++; $display("FAIL pos_old_gone got=%0h exp=0", bus_if.RE); end
        active = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        active = 1'b0; bus_if.wr_req = 1'b1; bus_if.wr_addr = 9'd5; bus_if.wr_data = 3'b111;
        @(negedge clk);
        tests++; if (bus_if.WE !== 1'b1) begin fails++; $display("FAIL rstw_pre got=%0h exp=1", bus_if.WE); end
        rst = 1'b1; bus_if.wr_req = 1'b0;
        #1;
        tests++; if (bus_if.WE !== 1'b0 || bus_if.wr_ack !== 1'b0) begin fails++; $display("FAIL rstw_clear got=%0h/%0h exp=0/0", bus_if.WE, bus_if.wr_ack); end
        @(negedge clk);
        rst = 1'b0;
        // live position is now (0,0): (3,1) -> address 19, colour 3
        px(8'd3, 8'd1, 1'b1);
        repeat (3) @(negedge clk);
        tests++; if (pix_hit !== 1'b1 || pix_color !== 3'b011) begin fails++; $display("FAIL rstl_pre got=%0h/%0h exp=1/3", pix_hit, pix_color); end
        rst = 1'b1;
        #1;
        tests++; if (pix_hit !== 1'b0 || pix_color !== 3'b000 || bus_if.RE !== 1'b0) begin fails++; $display("FAIL rstl_clear got=%0h/%0h/%0h exp=0/0/0", pix_hit, pix_color, bus_if.RE); end
        @(negedge clk);
        rst = 1'b0; active = 1'b0;
        px(8'd3, 8'd1, 1'b1);
        @(negedge clk);
        active = 1'b0;
        tests++; if (pix_hit !== 1'b0) begin fails++; $display("FAIL rstl_lat1 got=%0h exp=0", pix_hit); end
        @(negedge clk);
        tests++; if (pix_hit !== 1'b0) begin fails++; $display("FAIL rstl_lat2 got=%0h exp=0", pix_hit); end
        @(negedge clk);
        tests++; if (pix_hit !== 1'b1 || pix_color !== 3'b011) begin fails++; $display("FAIL rstl_first got=%0h/%0h exp=1/3", pix_hit, pix_color); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] addrs [3];
        logic [2:0] datas [3];
        int k;
        addrs[0] = 9'd10; addrs[1] = 9'd11; addrs[2] = 9'd12;
        datas[0] = 3'd1;  datas[1] = 3'd2;  datas[2] = 3'd3;
        k = 0;
        @(negedge clk);
        active = 1'b0; bus_if.wr_req = 1'b1; bus_if.wr_addr = addrs[0]; bus_if.wr_data = datas[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++; if (bus_if.wr_ack !== 1'((c % 2) == 0) || bus_if.WE !== 1'((c % 2) == 0)) begin fails++; $display("FAIL b2b_ack c=%0d got=%0h/%0h exp=%0h", c, bus_if.wr_ack, bus_if.WE, (c % 2) == 0); end
            if ((c % 2) == 0 && k < 3) begin
                tests++; if (bus_if.wAddr !== addrs[k] || bus_if.dataIn !== datas[k]) begin fails++; $display("FAIL b2b_order k=%0d got=%0h/%0h exp=%0h/%0h", k, bus_if.wAddr, bus_if.dataIn, addrs[k], datas[k]); end
                k++;
                if (k == 3) bus_if.wr_req = 1'b0;
                else begin bus_if.wr_addr = addrs[k]; bus_if.wr_data = datas[k]; end
            end
        end
        // stream three adjacent pixels through the read path
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                tests++; if (pix_hit !== 1'b1 || pix_color !== datas[i-3]) begin fails++; $display("FAIL b2b_read i=%0d got=%0h/%0h exp=1/%0h", i - 3, pix_hit, pix_color, datas[i-3]); end
            end
            if (i < 3) begin hcount = 8'(10 + i); vcount = 8'd0; active = 1'b1; end
            else active = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        hcount = '0; vcount = '0; active = 1'b0; frame_start = 1'b0;
        card_x = '0; card_y = '0; pos_load = 1'b0;
        bus_if.wr_req = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
        test_reset;
        test_hit;
        test_bounds;
        test_write_arb;
        test_clip;
        test_pos_latch;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
